// File: rtl/ws2811_pkg.sv
// Shared WS2811 definitions: pixel width, default 50 MHz bit timing and the receiver state type.
// The colour-order rotate helper is the inverse of the transmitter's rotate-left.
package ws2811_pkg;

    localparam int PIXEL_BITS       = 24;
    localparam int T0H_CYCLES       = 18;
    localparam int T1H_CYCLES       = 35;
    localparam int RESET_CYCLES_DEF = 2500;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    // Amounts of PIXEL_BITS or more are treated as no rotation.
    function automatic logic [PIXEL_BITS-1:0] rotr_pixel(input logic [PIXEL_BITS-1:0] w,
                                                          input logic [4:0]            s);
        logic [2*PIXEL_BITS-1:0] dbl;
        logic [4:0]              amt;
        amt = (s >= 5'(PIXEL_BITS)) ? 5'd0 : s;
        dbl = {w, w} >> amt;
        return dbl[PIXEL_BITS-1:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ws2811_pixel_receiver.sv
// WS2811 NRZ receiver: captures the first 24-bit word of each frame (rotated right by shiftIN)
// and re-drives every later bit of the frame on doutOUT, like a physical pixel.
module ws2811_pixel_receiver
    import ws2811_pkg::*;
#(
    parameter int T1_THRESH_CYCLES = 26,
    parameter int MAX_HIGH_CYCLES  = 100,
    parameter int RESET_CYCLES     = 2500,
    parameter int CNT_W            = 12
) (
    input  logic        clkIN,
    input  logic        nRstIN,
    input  logic        dinIN,
    input  logic [4:0]  shiftIN,
    output logic [23:0] pixelOUT,
    output logic        pixelValidOUT,
    output logic        frameEndOUT,
    output logic        errorOUT,
    output logic        doutOUT
);

    localparam logic [CNT_W-1:0] T1_C    = CNT_W'(T1_THRESH_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [4:0]       NBITS_C = 5'(PIXEL_BITS);
    localparam logic [4:0]       LAST_C  = 5'(PIXEL_BITS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + ONE_C;
    endfunction

    logic                  din_s;
    logic                  din_prev_q;
    logic                  rise, fall;
    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [PIXEL_BITS-1:0] cap_q, cap_d;
    logic                  load_q, load_d;
    logic                  fwd_en_q, fwd_en_d;
    logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
    logic                  valid_q, valid_d;
    logic                  frame_end_q, frame_end_d;
    logic                  error_q, error_d;
    logic                  dout_q, dout_d;

    sync_2ff u_sync (
        .clk   (clkIN),
        .rst_n (nRstIN),
        .d     (dinIN),
        .q     (din_s)
    );

    always_comb begin
        rise        = din_s & ~din_prev_q;
        fall        = ~din_s & din_prev_q;
        cnt_inc     = sat_inc(cnt_q);
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cap_d       = cap_q;
        load_d      = 1'b0;
        fwd_en_d    = fwd_en_q;
        pixel_d     = pixel_q;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        error_d     = 1'b0;

        // The cycle after the 24th fall publishes the word, using shiftIN as it is now.
        if (load_q) begin
            pixel_d  = rotr_pixel(cap_q, shiftIN);
            valid_d  = 1'b1;
            fwd_en_d = 1'b1;
        end

        case (state_q)
            SYNC: begin
                cnt_d = din_s ? '0 : cnt_inc;
                if (!din_s && cnt_inc >= RESET_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = ONE_C;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    cnt_d   = ONE_C;
                    if (bit_cnt_q < NBITS_C) begin
                        cap_d     = {cap_q[PIXEL_BITS-2:0], (cnt_q >= T1_C)};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        load_d    = (bit_cnt_q == LAST_C);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc > MAX_C) begin
                        error_d   = 1'b1;
                        fwd_en_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = SYNC;
                        cnt_d     = '0;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= RESET_C) begin
                        frame_end_d = 1'b1;
                        bit_cnt_d   = '0;
                        fwd_en_d    = 1'b0;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        dout_d = din_s & fwd_en_q;
    end

    always_ff @(posedge clkIN or negedge nRstIN) begin
        if (!nRstIN) begin
            din_prev_q  <= 1'b0;
            state_q     <= SYNC;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            load_q      <= 1'b0;
            fwd_en_q    <= 1'b0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            error_q     <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            din_prev_q  <= din_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            load_q      <= load_d;
            fwd_en_q    <= fwd_en_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            error_q     <= error_d;
            dout_q      <= dout_d;
        end
    end

    // Shift register contents are only consumed after 24 fresh bits, so it needs no reset.
    always_ff @(posedge clkIN) begin
        cap_q <= cap_d;
    end

    assign pixelOUT      = pixel_q;
    assign pixelValidOUT = valid_q;
    assign frameEndOUT   = frame_end_q;
    assign errorOUT      = error_q;
    assign doutOUT       = dout_q;

endmodule

// File: tb/tb_ws2811_pixel_receiver.sv
// Bench for ws2811_pixel_receiver: pulse-level reference model of the WS2811 line protocol,
// directed scenarios plus randomized frames, with a per-cycle output compare process.
module tb_ws2811_pixel_receiver;

    localparam int T1_TH = 26;
    localparam int MAXH  = 100;
    localparam int RSTC  = 2500;
    localparam int HMAX  = 1 << 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [4:0]  shift = 5'd0;
    logic [23:0] pix;
    logic        vld, fe, err, dout;

    int checks = 0;
    int errors = 0;

    ws2811_pixel_receiver dut (
        .clkIN         (clk),
        .nRstIN        (rst_n),
        .dinIN         (din),
        .shiftIN       (shift),
        .pixelOUT      (pix),
        .pixelValidOUT (vld),
        .frameEndOUT   (fe),
        .errorOUT      (err),
        .doutOUT       (dout)
    );

    always #5 clk = ~clk;

    // Reference model state (line-protocol level).
    bit          synced = 1'b0;
    bit          in_frame = 1'b0;
    bit          fwd = 1'b0;
    int          low_run = 0;
    int          nbits = 0;
    logic [23:0] word = '0;
    int          fe_exp = 0;
    int          err_exp = 0;
    logic [23:0] pix_q[$];
    logic [23:0] pix_hold = '0;

    // Observed DUT events.
    int fe_seen = 0;
    int err_seen = 0;
    int vld_seen = 0;
    int dout_hi_seen = 0;
    int cyc = 0;
    bit din_hist[HMAX];
    bit fwd_hist[HMAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] ref_rot(input logic [23:0] w, input int s);
        logic [23:0] r;
        int k;
        k = (s >= 24) ? 0 : s;
        for (int i = 0; i < 24; i++) r[i] = w[(i + k) % 24];
        return r;
    endfunction

    task automatic model_low_tick();
        low_run++;
        if (low_run == RSTC) begin
            if (!synced) begin
                synced = 1'b1;
            end else if (in_frame) begin
                fe_exp++;
                in_frame = 1'b0;
                nbits = 0;
                fwd = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = v;
            if (cyc + 1 < HMAX) begin
                din_hist[cyc + 1] = v;
                fwd_hist[cyc + 1] = fwd;
            end
            if (!v) model_low_tick();
        end
    endtask

    task automatic hi(input int h);
        drive(1'b1, h);
        low_run = 0;
        if (synced) begin
            if (h > MAXH) begin
                err_exp++;
                synced = 1'b0;
                in_frame = 1'b0;
                nbits = 0;
                fwd = 1'b0;
            end else begin
                in_frame = 1'b1;
                if (nbits < 24) begin
                    word = {word[22:0], (h >= T1_TH)};
                    nbits++;
                    if (nbits == 24) begin
                        pix_q.push_back(ref_rot(word, int'(shift)));
                        fwd = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic lo(input int n);
        drive(1'b0, n);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin hi(35); lo(28); end
        else   begin hi(18); lo(45); end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_rand_bit(input logic b);
        int h;
        h = b ? int'($urandom_range(26, 45)) : int'($urandom_range(1, 25));
        hi(h);
        lo(int'($urandom_range(2, 25)));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_end_count"}, 32'(fe_seen), 32'(fe_exp));
        check({tag, "_error_count"}, 32'(err_seen), 32'(err_exp));
        check({tag, "_pending_pixels"}, 32'(pix_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel"}, 32'(pix), 32'd0);
        check({tag, "_valid"}, 32'(vld), 32'd0);
        check({tag, "_frame_end"}, 32'(fe), 32'd0);
        check({tag, "_error"}, 32'(err), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    task automatic model_reset();
        synced = 1'b0;
        in_frame = 1'b0;
        fwd = 1'b0;
        nbits = 0;
        low_run = 0;
        pix_q.delete();
        pix_hold = '0;
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (vld) begin
                vld_seen++;
                check("valid_expected", 32'(pix_q.size() != 0), 32'd1);
                if (pix_q.size() != 0) pix_hold = pix_q.pop_front();
                check("pixel", 32'(pix), 32'(pix_hold));
            end else begin
                check("pixel_hold", 32'(pix), 32'(pix_hold));
            end
            if (fe) fe_seen++;
            if (err) err_seen++;
            if (dout) dout_hi_seen++;
            if (cyc >= 2 && cyc < HMAX)
                check("dout", 32'(dout), 32'(din_hist[cyc - 2] & fwd_hist[cyc - 2]));
        end
    end

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, vld0, hi0, err0;
        logic [63:0] rw;
        int nb;

        drive(1'b0, 5);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        lo(2600);

        // 1: plain word, no rotation, nothing forwarded
        fe0 = fe_seen; vld0 = vld_seen; hi0 = dout_hi_seen;
        shift = 5'd0;
        send_bits(64'hA5C33C, 24);
        lo(2500);
        lo(5);
        check("t1_pixel", 32'(pix), 32'hA5C33C);
        check("t1_valid_pulses", 32'(vld_seen - vld0), 32'd1);
        check("t1_frame_end", 32'(fe_seen - fe0), 32'd1);
        check("t1_dout_idle", 32'(dout_hi_seen - hi0), 32'd0);
        check_counts("t1");

        // 2: rotate-right by 8, then an out-of-range amount
        shift = 5'd8;
        send_bits(64'h123456, 24);
        lo(2500);
        check("t2_rot8", 32'(pix), 32'h561234);
        shift = 5'd27;
        send_bits(64'h123456, 24);
        lo(2500);
        check("t2_rot27", 32'(pix), 32'h123456);
        shift = 5'd5;
        lo(10);
        check("t2_shift_change_no_recompute", 32'(pix), 32'h123456);
        check_counts("t2");

        // 3: 48-bit frame, second word forwarded
        shift = 5'd0;
        hi0 = dout_hi_seen;
        send_bits(64'h00FF00, 24);
        send_bits(64'hABCDEF, 24);
        lo(2500);
        lo(5);
        check("t3_pixel", 32'(pix), 32'h00FF00);
        check("t3_dout_high_cycles", 32'(dout_hi_seen - hi0), 32'd721);
        check_counts("t3");

        // 4a: exactly 2500 low cycles after the word ends the frame
        fe0 = fe_seen;
        send_bits(64'h0F0F0F >> 1, 23);
        hi(35);
        lo(2500);
        lo(5);
        check("t4a_frame_end", 32'(fe_seen - fe0), 32'd1);
        check("t4a_pixel", 32'(pix), 32'h0F0F0F);

        // 4b: 2499 low cycles do not end the frame; next bit is forwarded
        fe0 = fe_seen; hi0 = dout_hi_seen;
        send_bits(64'h0F0F0F >> 1, 23);
        hi(35);
        lo(2499);
        check("t4b_no_frame_end", 32'(fe_seen - fe0), 32'd0);
        hi(35);
        lo(2500);
        lo(5);
        check("t4b_frame_end", 32'(fe_seen - fe0), 32'd1);
        check("t4b_forwarded", 32'(dout_hi_seen - hi0), 32'd35);
        check_counts("t4");

        // 5: threshold 25/26, 100-cycle high is legal, 101 is an error
        begin
            logic [23:0] tw;
            tw = 24'h5A5A5A;
            for (int i = 23; i >= 0; i--) begin
                if (tw[i]) hi((i == 22) ? 100 : 26);
                else       hi(25);
                lo(40);
            end
            lo(2500);
        end
        check("t5_threshold_pixel", 32'(pix), 32'h5A5A5A);
        err0 = err_seen; vld0 = vld_seen;
        send_bits(64'h1F, 5);
        hi(101);
        lo(40);
        send_bits(64'hFF, 8);
        lo(100);
        check("t5_error_pulse", 32'(err_seen - err0), 32'd1);
        check("t5_no_valid", 32'(vld_seen - vld0), 32'd0);
        check("t5_pixel_kept", 32'(pix), 32'h5A5A5A);
        lo(2500);
        send_bits(64'h3C3C3C, 24);
        lo(2500);
        check("t5_resync_pixel", 32'(pix), 32'h3C3C3C);
        check_counts("t5");

        // 6: reset in the middle of a word
        send_bits(64'hC0FFEE >> 12, 12);
        drive(1'b1, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("t6_async_reset");
        lo(4);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        vld0 = vld_seen;
        lo(100);
        send_bits(64'h777777, 24);
        lo(2500);
        check("t6_unsynced_ignored", 32'(vld_seen - vld0), 32'd0);
        send_bits(64'h777777, 24);
        lo(2500);
        check("t6_pixel", 32'(pix), 32'h777777);
        fe0 = fe_seen; vld0 = vld_seen;
        send_bits(64'hABC, 12);
        lo(2500);
        lo(5);
        check("t6_partial_frame_end", 32'(fe_seen - fe0), 32'd1);
        check("t6_partial_no_valid", 32'(vld_seen - vld0), 32'd0);
        check("t6_partial_pixel_kept", 32'(pix), 32'h777777);
        check_counts("t6");

        // Randomized frames: random length, widths and rotation.
        for (int f = 0; f < 6; f++) begin
            shift = 5'($urandom_range(0, 31));
            rw = {$urandom, $urandom};
            nb = int'($urandom_range(1, 40));
            for (int i = nb - 1; i >= 0; i--) send_rand_bit(rw[i]);
            lo(RSTC + int'($urandom_range(0, 20)));
            lo(5);
            check_counts("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2811_pixel_receiver.md
Name: ws2811_pixel_receiver

Overview:
- Decodes the WS2811 one-wire NRZ stream, which is the receive end of the strip driver's transmit path.
- Captures the first 24-bit pixel word of each frame, undoes the driver's colour-order rotate-left by rotating right, and forwards all later bits unchanged on a re-drive output, like a physical WS2811 pixel.
- Used for on-board loopback checking and for chained-pixel emulation.

Parameters:
T1_THRESH_CYCLES, 26, high-pulse width in clkIN cycles at or above which a bit decodes as 1.
MAX_HIGH_CYCLES, 100, high-pulse width above which the bit is a line error.
RESET_CYCLES, 2500, low time marking frame end/latch (50 us at 50 MHz).
CNT_W, 12, width of the pulse counter; must hold RESET_CYCLES.

Ports:
clkIN  input  1  system clock; the only clock.
nRstIN  input  1  asynchronous active-low reset.
dinIN  input  1  asynchronous WS2811 serial line.
shiftIN  input  5  rotate-right amount 0..23 applied to the captured word; values 24..31 act as 0.
pixelOUT  output  24  last captured pixel, rotated right by shiftIN.
pixelValidOUT  output  1  one-cycle pulse when pixelOUT updates.
frameEndOUT  output  1  one-cycle pulse on detection of the reset gap.
errorOUT  output  1  one-cycle pulse on an over-long high pulse.
doutOUT  output  1  re-driven stream (bits 25 onward of the frame).

Behaviour:
- Reset: asynchronous on nRstIN low. All outputs 0, counters 0, fwdEn 0, state SYNC.
- Input: dinIN passes through a 2-flop synchroniser (din_s). Rise and fall edges are detected on din_s against its previous value.
- Bit order: MSB first. The first received bit lands in capture bit 23.
- SYNC state:
  - Count cycles while din_s is low; any high clears the count.
  - Count reaching RESET_CYCLES -> IDLE. No frameEndOUT is generated from SYNC.
- IDLE state: rise -> HIGH with cnt=1.
- HIGH state:
  - cnt increments each cycle.
  - cnt > MAX_HIGH_CYCLES -> pulse errorOUT, clear fwdEn and bitCnt, go to SYNC.
  - fall -> decode the bit as (cnt >= T1_THRESH_CYCLES), then go to LOW with cnt=1.
  - If bitCnt < 24, shift the bit into the capture register and increment bitCnt.
- 24th bit:
  - On the fall that completes bit 24, the next cycle loads pixelOUT = capture rotated right by shiftIN. shiftIN is sampled in that cycle.
  - pixelValidOUT pulses for exactly one cycle, and fwdEn is set in the same cycle.
- LOW state:
  - rise -> HIGH with cnt=1.
  - cnt reaching RESET_CYCLES -> pulse frameEndOUT, clear bitCnt and fwdEn, go to IDLE.
- Incomplete frame: a frame end with 1..23 bits captured discards the partial word. pixelOUT holds its old value and no valid pulse is issued.
- Re-drive: doutOUT is registered as din_s AND fwdEn. Latency from dinIN to doutOUT is 3 cycles.
  - fwdEn rises after the 24th fall, so the 25th high pulse is forwarded whole.
  - Pulse widths are preserved cycle-exact.
- Simultaneous events: the frame-end comparison is only evaluated in LOW, so it cannot coincide with a rise in the same cycle.
- Counter: cnt saturates at its maximum and never wraps.
- Mid-operation events:
  - nRstIN asserted mid-word aborts immediately.
  - A new shiftIN value affects only the next capture; pixelOUT is not recomputed.

Decomposition:
- Shared package ws2811_pkg holds:
  - PIXEL_BITS = 24.
  - The default timing constants T0H/T1H/RESET in cycles at 50 MHz, shared with the transmitter.
  - typedef rx_state_t {SYNC, IDLE, HIGH, LOW}.
- One sub-module is natural: sync_2ff, the single-bit 2-flop synchroniser, which can be reused elsewhere.
- The rotate-right is combinational inside the block and is the inverse of the existing rotate-left shifter.

Test Plan:
Bit timing for all scenarios: 0 = 18 cycles high, 45 low; 1 = 35 cycles high, 28 low.
1. Release reset with din low for 2500 cycles, send 0xA5C33C, shiftIN=0 -> one pixelValidOUT pulse, pixelOUT=0xA5C33C, doutOUT stays 0.
2. shiftIN=8, send 0x123456 -> pixelOUT=0x561234. With shiftIN=27, 0x123456 -> pixelOUT=0x123456.
3. Send a 48-bit frame 0x00FF00, 0xABCDEF -> pixelOUT=0x00FF00. doutOUT reproduces the 0xABCDEF waveform delayed 3 cycles with identical pulse widths.
4. After the word, hold low 2500 cycles -> exactly one frameEndOUT pulse. A 2499-cycle gap -> none, and the next bit is forwarded on doutOUT.
5. Threshold and error:
   - High 25 cycles decodes 0; high 26 decodes 1.
   - High 101 cycles -> errorOUT pulse and no pixelValidOUT.
   - Bits sent before a 2500-cycle low are then ignored.
6. Assert nRstIN at bit 12 -> all outputs 0 immediately. A following full word is accepted only after the 2500-cycle sync gap, and 12 bits then a gap -> no valid pulse.
